keypad_entry_ctrl: RTL and testbench

- Controller between the 3x4 keypad scanner and the 4-digit 7-segment display driver.
- Takes the scanner's level key outputs, validates and debounces them, and turns each accepted press into an edit of a 4-digit hex entry buffer.
- Drives the display's hexx/mask/points inputs and publishes the committed value with a one-cycle valid strobe.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/key_debounce.sv | 71 +++++++
 rtl/keypad_entry_ctrl.sv | 146 ++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key-vector helpers for the keypad entry controller.
// Key codes: digits 0-9 use their bit index, '*' and '#' follow.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACT, HELD} state_e;

  localparam logic [3:0] KEY_AST  = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  function automatic logic onehot_valid(input logic [11:0] kv);
    return (kv != 12'd0) && ((kv & (kv - 12'd1)) == 12'd0);
  endfunction

  function automatic logic [3:0] encode_key(input logic [11:0] kv);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (kv[i]) code = 4'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Validates the 12-bit key vector, debounces press and release, and emits one
// strobe per accepted press (combinational in the ACT state, gated by en).
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] kv_i,
  output logic        key_strobe,
  output logic [3:0]  key_code,
  output logic        quiet_o
);

  localparam int CW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  state_e        state_q, state_d;
  logic [11:0]   kv_q, kv_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      kv_q    <= '0;
      cnt_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      kv_q    <= kv_d;
      cnt_q   <= cnt_d;
    end
  end

  // The same counter measures press stability and then release stability.
  always_comb begin
    state_d = state_q;
    kv_d    = kv_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (onehot_valid(kv_i)) begin
          kv_d    = kv_i;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (kv_i != kv_q)          state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = ACT;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      ACT: begin
        cnt_d   = '0;
        state_d = HELD;
      end
      HELD: begin
        if (kv_i != 12'd0)          cnt_d   = '0;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_strobe = en && (state_q == ACT);
  assign key_code   = encode_key(kv_q);
  assign quiet_o    = (state_q == IDLE) || (state_q == HELD);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad-to-display controller: 4-digit hex entry buffer, backspace, commit,
// inactivity timeout and cursor blink; display outputs lag state by one clk.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int BLINK_TICKS    = 64,
  parameter int TIMEOUT_TICKS  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [9:0]  numbers,
  input  logic        asterisk,
  input  logic        hash,
  output logic [15:0] hexx,
  output logic [3:0]  mask,
  output logic [3:0]  points,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        editing
);

  localparam int BW = $clog2(BLINK_TICKS) + 1;
  localparam int TW = $clog2(TIMEOUT_TICKS) + 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_TICKS - 1);

  logic       key_strobe, quiet;
  logic [3:0] key_code;

  key_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .kv_i       ({hash, asterisk, numbers}),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .quiet_o    (quiet)
  );

  logic [15:0]   buf_q, buf_d, value_q, value_d, hexx_q, hexx_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [3:0]    mask_q, mask_d, points_q, points_d;
  logic          pt_q, pt_d, vv_q, vv_d, editing_q, editing_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q     <= '0;
      cnt_q     <= '0;
      value_q   <= '0;
      vv_q      <= 1'b0;
      tmo_q     <= '0;
      blink_q   <= '0;
      pt_q      <= 1'b1;
      hexx_q    <= '0;
      mask_q    <= '0;
      points_q  <= '0;
      editing_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      value_q   <= value_d;
      vv_q      <= vv_d;
      tmo_q     <= tmo_d;
      blink_q   <= blink_d;
      pt_q      <= pt_d;
      hexx_q    <= hexx_d;
      mask_q    <= mask_d;
      points_q  <= points_d;
      editing_q <= editing_d;
    end
  end

  // A key action on the same tick as the timeout takes priority over it.
  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    vv_d    = 1'b0;
    tmo_d   = tmo_q;
    if (key_strobe) begin
      tmo_d = '0;
      if (key_code < 4'd10) begin
        if (cnt_q != 3'd4) begin
          buf_d = {buf_q[11:0], key_code};
          cnt_d = cnt_q + 3'd1;
        end
      end else if (cnt_q != 3'd0) begin
        if (key_code == KEY_AST) begin
          buf_d = buf_q >> 4;
          cnt_d = cnt_q - 3'd1;
        end else if (key_code == KEY_HASH) begin
          value_d = buf_q;
          vv_d    = 1'b1;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end
    end else if (en && (TIMEOUT_TICKS != 0) && (cnt_q != 3'd0) && quiet) begin
      if (tmo_q == TMO_LAST) begin
        buf_d = '0;
        cnt_d = '0;
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_comb begin
    blink_d = blink_q;
    pt_d    = pt_q;
    if (cnt_q == 3'd0) begin
      blink_d = '0;
      pt_d    = 1'b1;
    end else if (en) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        pt_d    = ~pt_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end
  end

  always_comb begin
    editing_d = (cnt_q != 3'd0);
    hexx_d    = editing_d ? buf_q : value_q;
    points_d  = editing_d ? {3'b000, pt_q} : 4'b0000;
    mask_d    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      mask_d[i] = editing_d && (3'(i) >= cnt_q);
    end
  end

  assign hexx        = hexx_q;
  assign mask        = mask_q;
  assign points      = points_q;
  assign value       = value_q;
  assign value_valid = vv_q;
  assign editing     = editing_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed and randomized bench for keypad_entry_ctrl, checked every clock
// against a run-length reference model of press/release acceptance.
module tb_keypad_entry_ctrl;

  localparam int DEB = 4;
  localparam int BLK = 8;
  localparam int TMO = 16;
  localparam logic [11:0] KV_AST  = 12'h400;
  localparam logic [11:0] KV_HASH = 12'h800;

  logic        clk = 1'b0;
  logic        rst, en, asterisk, hash;
  logic [9:0]  numbers;
  logic [15:0] hexx, value;
  logic [3:0]  mask, points;
  logic        value_valid, editing;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  // Reference model: run lengths of stable press / stable release.
  int          m_buf, m_cnt, m_value, m_tmo, m_edit, m_run, m_zrun;
  logic [11:0] m_cand;
  bit          m_act, m_rel;

  keypad_entry_ctrl #(
    .DEBOUNCE_TICKS(DEB), .BLINK_TICKS(BLK), .TIMEOUT_TICKS(TMO)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .numbers(numbers), .asterisk(asterisk),
    .hash(hash), .hexx(hexx), .mask(mask), .points(points), .value(value),
    .value_valid(value_valid), .editing(editing)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] dig(input int d);
    logic [11:0] one;
    one = 12'd1;
    return one << d;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_buf = 0; m_cnt = 0; m_value = 0; m_tmo = 0; m_edit = 0;
    m_run = 0; m_zrun = 0; m_cand = '0; m_act = 0; m_rel = 0;
  endtask

  task automatic model_tick(input logic [11:0] kv, output logic vv);
    bit quiet;
    int was_cnt, code;
    quiet   = m_rel || (!m_act && m_run == 0);
    was_cnt = m_cnt;
    vv      = 1'b0;
    if (m_act) begin
      code = 0;
      for (int i = 0; i < 12; i++) if (m_cand[i]) code = i;
      if (code < 10) begin
        if (m_cnt < 4) begin m_buf = (m_buf * 16 + code) % 65536; m_cnt++; end
      end else if (code == 10) begin
        if (m_cnt > 0) begin m_buf = m_buf / 16; m_cnt--; end
      end else if (m_cnt > 0) begin
        m_value = m_buf; vv = 1'b1; m_buf = 0; m_cnt = 0;
      end
      m_tmo = 0; m_act = 0; m_rel = 1; m_zrun = 0; m_run = 0;
    end else begin
      if (m_rel) begin
        m_zrun = (kv == 12'd0) ? m_zrun + 1 : 0;
        if (m_zrun == DEB) m_rel = 0;
      end else if (m_run > 0 && kv != m_cand) m_run = 0;
      else if (m_run > 0) m_run++;
      else if ($countones(kv) == 1) begin m_cand = kv; m_run = 1; end
      if (m_run == DEB + 1) m_act = 1;
      if (was_cnt > 0 && quiet) begin
        m_tmo++;
        if (m_tmo == TMO) begin m_buf = 0; m_cnt = 0; m_tmo = 0; end
      end
    end
    m_edit = (was_cnt > 0) ? m_edit + 1 : 0;
  endtask

  task automatic cyc(input logic [11:0] kv, input logic e);
    logic [15:0] eh;
    logic [3:0]  em, ep;
    logic        ee, evv;
    {hash, asterisk, numbers} = kv;
    en = e;
    @(posedge clk);
    ee = (m_cnt > 0);
    eh = ee ? 16'(m_buf) : 16'(m_value);
    em = 4'b0000;
    for (int i = 0; i < 4; i++) em[i] = ee && (i >= m_cnt);
    ep = {3'b000, ee && ((m_edit / BLK) % 2 == 0)};
    evv = 1'b0;
    if (e) model_tick(kv, evv);
    @(negedge clk);
    chk("hexx", hexx, eh);
    chk("mask", 16'(mask), 16'(em));
    chk("points", 16'(points), 16'(ep));
    chk("value", value, 16'(m_value));
    chk("value_valid", 16'(value_valid), 16'(evv));
    chk("editing", 16'(editing), 16'(ee));
    if (value_valid) pulses++;
  endtask

  task automatic press(input logic [11:0] kv, input int hold);
    repeat (hold) cyc(kv, 1'b1);
    repeat (10) cyc(12'd0, 1'b1);
  endtask

  task automatic check_all_zero(input string p);
    chk({p, "_hexx"}, hexx, 16'h0);
    chk({p, "_mask"}, 16'(mask), 16'h0);
    chk({p, "_points"}, 16'(points), 16'h0);
    chk({p, "_value"}, value, 16'h0);
    chk({p, "_value_valid"}, 16'(value_valid), 16'h0);
    chk({p, "_editing"}, 16'(editing), 16'h0);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; numbers = '0; asterisk = 1'b0; hash = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill the buffer; the fifth digit must be ignored.
    for (int d = 1; d <= 5; d++) press(dig(d), 10);
    chk("fill_hexx", hexx, 16'h1234);
    chk("fill_mask", 16'(mask), 16'h0);
    chk("fill_editing", 16'(editing), 16'h1);
    repeat (20) cyc(12'd0, 1'b1);
    chk("idle_clear_editing", 16'(editing), 16'h0);
    chk("idle_clear_value", value, 16'h0);

    // Digits, backspace, commit.
    pulses = 0;
    press(dig(7), 10); press(dig(8), 10); press(KV_AST, 10); press(KV_HASH, 10);
    chk("commit_pulses", 16'(pulses), 16'd1);
    chk("commit_value", value, 16'h0007);
    chk("commit_hexx", hexx, 16'h0007);
    chk("commit_mask", 16'(mask), 16'h0);
    chk("commit_points", 16'(points), 16'h0);
    chk("commit_editing", 16'(editing), 16'h0);

    // Short glitch and a multi-key chord are both rejected.
    pulses = 0;
    repeat (2) cyc(dig(3), 1'b1);
    repeat (10) cyc(12'd0, 1'b1);
    repeat (10) cyc(12'h003, 1'b1);
    repeat (10) cyc(12'd0, 1'b1);
    chk("glitch_pulses", 16'(pulses), 16'd0);
    chk("glitch_editing", 16'(editing), 16'h0);
    chk("glitch_hexx", hexx, 16'h0007);

    // Long '#' hold commits exactly once; with an empty buffer it does nothing.
    press(dig(1), 10); press(dig(2), 10);
    pulses = 0;
    press(KV_HASH, 200);
    chk("hold_commit_pulses", 16'(pulses), 16'd1);
    chk("hold_commit_value", value, 16'h0012);
    pulses = 0;
    press(KV_HASH, 200);
    chk("hold_empty_pulses", 16'(pulses), 16'd0);
    chk("hold_empty_value", value, 16'h0012);

    // Inactivity timeout discards an uncommitted entry.
    press(dig(9), 10);
    chk("tmo_pre_editing", 16'(editing), 16'h1);
    chk("tmo_pre_hexx", hexx, 16'h0009);
    chk("tmo_pre_mask", 16'(mask), 16'h000e);
    repeat (16) cyc(12'd0, 1'b1);
    chk("tmo_editing", 16'(editing), 16'h0);
    chk("tmo_value", value, 16'h0012);
    chk("tmo_hexx", hexx, 16'h0012);

    // Asynchronous reset in the middle of a debounce.
    press(dig(1), 10); press(dig(2), 10); press(dig(3), 10);
    repeat (3) cyc(dig(4), 1'b1);
    chk("prerst_hexx", hexx, 16'h0123);
    {hash, asterisk, numbers} = 12'd0;
    rst = 1'b1;
    #1 check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    press(dig(5), 10);
    chk("postrst_hexx", hexx, 16'h0005);
    chk("postrst_editing", 16'(editing), 16'h1);
    chk("postrst_mask", 16'(mask), 16'h000e);

    // Randomized keys, durations and enable gaps.
    for (int s = 0; s < 150; s++) begin
      int          r, a, b, len;
      logic [11:0] kv;
      r   = $urandom_range(0, 9);
      a   = $urandom_range(0, 11);
      b   = (a + 1 + $urandom_range(0, 10)) % 12;
      len = $urandom_range(1, 12);
      if (r <= 6)      kv = dig(a);
      else if (r == 7) kv = 12'd0;
      else if (r == 8) kv = dig(a) | dig(b);
      else begin kv = dig(a); len = $urandom_range(1, 4); end
      for (int c = 0; c < len; c++) cyc(kv, 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 8)) cyc(12'd0, 1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
